// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Four-digit time-multiplexed seven-segment display driver. A 16-bit packed
// hex value is accepted through a valid/ready handshake into a one-entry
// pending buffer and copied into the displayed value only at a frame
// boundary, so a frame never mixes old and new digits. Each digit slot lasts
// SCAN_DIV clocks, is PWM-dimmed by the brightness code, and may be blanked
// when it is a leading zero.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   digits_in  packed hex digits, [3:0] = digit 0 ... [15:12] = digit 3
//   ld_valid   digits_in valid
//   ld_ready   driver can accept a value (no value pending)
//   brightness PWM duty code, 0 = dimmest, 7 = full on
//   blank_lz   enable leading-zero blanking
//   seg        active-high segments, bit0 = a ... bit6 = g (registered)
//   dig_en     active-high one-hot digit enables (registered)
//   frame_tick one-cycle pulse after each completed frame (registered)
module seg7_scan_driver #(
    parameter int SCAN_DIV = 6250
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] digits_in,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [2:0]  brightness,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic [3:0]  dig_en,
    output logic        frame_tick
);

    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

    logic [15:0] div_cnt;
    logic [1:0]  idx;
    logic [15:0] disp_reg;
    logic [15:0] pend_reg;
    logic        pend_flag;

    logic        slot_end;
    logic        frame_end;
    logic        accept;
    logic [18:0] on_limit;
    logic        lit;
    logic [15:0] disp_shift;
    logic [3:0]  cur_nib;
    logic        upper_zero;
    logic        show;
    logic [6:0]  cur_seg;

    // Hex nibble to active-high segment pattern (g..a).
    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0: decode = 7'b0111111;
            4'h1: decode = 7'b0000110;
            4'h2: decode = 7'b1011011;
            4'h3: decode = 7'b1001111;
            4'h4: decode = 7'b1100110;
            4'h5: decode = 7'b1101101;
            4'h6: decode = 7'b1111101;
            4'h7: decode = 7'b0000111;
            4'h8: decode = 7'b1111111;
            4'h9: decode = 7'b1101111;
            4'hA: decode = 7'b1110111;
            4'hB: decode = 7'b1111100;
            4'hC: decode = 7'b0111001;
            4'hD: decode = 7'b1011110;
            4'hE: decode = 7'b1111001;
            default: decode = 7'b1110001;
        endcase
    endfunction

    assign ld_ready = !pend_flag;

    // Slot/frame boundaries, handshake acceptance and what the current slot
    // should show. The PWM limit is 19 bits wide so 8 x 65535 cannot overflow.
    always_comb begin
        slot_end   = (div_cnt == DIV_LAST);
        frame_end  = slot_end && (idx == 2'd3);
        accept     = ld_valid && !pend_flag;
        on_limit   = ((19'(brightness) + 19'd1) * 19'(SCAN_DIV)) >> 3;
        lit        = {3'b000, div_cnt} < on_limit;
        disp_shift = disp_reg >> {idx, 2'b00};
        cur_nib    = disp_shift[3:0];
        // Digit k is a leading zero when nibbles k..3 are all zero; digit 0
        // always stays visible so a zero value still shows "0".
        upper_zero = (idx != 2'd0) && (disp_shift == 16'h0000);
        show       = lit && !(blank_lz && upper_zero);
        cur_seg    = decode(cur_nib);
    end

    // Scan counters, pending buffer and frame-boundary swap. The swap uses the
    // flag from before this edge; an accept can only happen when that flag is
    // clear, so the two never fight over pend_flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt    <= 16'd0;
            idx        <= 2'd0;
            disp_reg   <= 16'h0000;
            pend_reg   <= 16'h0000;
            pend_flag  <= 1'b0;
            seg        <= 7'd0;
            dig_en     <= 4'd0;
            frame_tick <= 1'b0;
        end else begin
            if (slot_end) begin
                div_cnt <= 16'd0;
                idx     <= idx + 2'd1;
            end else begin
                div_cnt <= div_cnt + 16'd1;
            end

            if (frame_end && pend_flag) begin
                disp_reg  <= pend_reg;
                pend_flag <= 1'b0;
            end
            if (accept) begin
                pend_reg  <= digits_in;
                pend_flag <= 1'b1;
            end

            seg        <= show ? cur_seg : 7'd0;
            dig_en     <= show ? (4'b0001 << idx) : 4'd0;
            frame_tick <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
// Self-checking bench for seg7_scan_driver with SCAN_DIV = 8. A behavioural
// model tracks the cycle number since reset release and derives slot, phase,
// frame end, displayed and pending values with plain arithmetic; every cycle
// the packed outputs {seg, dig_en, frame_tick, ld_ready} are compared with it.
module tb_seg7_scan_driver;

    localparam int SD = 8;

    logic        clk;
    logic        rst_n;
    logic [15:0] digits_in;
    logic        ld_valid;
    logic        ld_ready;
    logic [2:0]  brightness;
    logic        blank_lz;
    logic [6:0]  seg;
    logic [3:0]  dig_en;
    logic        frame_tick;

    int total;
    int bad;

    // Behavioural model state.
    int          p;
    logic [15:0] m_disp;
    logic [15:0] m_pend;
    logic        m_pflag;
    logic [12:0] exp_vec;

    logic [6:0] seg_tab [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                 7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                 7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                                 7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

    wire [12:0] obs = {seg, dig_en, frame_tick, ld_ready};

    seg7_scan_driver #(.SCAN_DIV(SD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digits_in  (digits_in),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .brightness (brightness),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .dig_en     (dig_en),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        p       = 0;
        m_disp  = 16'h0000;
        m_pend  = 16'h0000;
        m_pflag = 1'b0;
    endtask

    // Drives one cycle of handshake input, predicts the outputs produced by
    // the coming clock edge, advances the model and lands 1 time unit after
    // the edge.
    task automatic applyStimulus(input logic v, input logic [15:0] d);
        int          slot;
        int          ph;
        int          lim;
        logic [15:0] upper;
        logic        on;
        logic        fe;
        logic [6:0]  e_seg;
        logic [3:0]  e_dig;
        ld_valid  = v;
        digits_in = d;
        slot  = (p / SD) % 4;
        ph    = p % SD;
        lim   = ((int'(brightness) + 1) * SD) / 8;
        upper = m_disp >> (4 * slot);
        on    = (ph < lim) && !(blank_lz && slot != 0 && upper == 16'h0000);
        e_seg = on ? seg_tab[upper[3:0]] : 7'd0;
        e_dig = on ? 4'(1 << slot) : 4'd0;
        fe    = (slot == 3) && (ph == SD - 1);
        if (fe && m_pflag) begin
            m_disp  = m_pend;
            m_pflag = 1'b0;
        end else if (v && !m_pflag) begin
            m_pend  = d;
            m_pflag = 1'b1;
        end
        p = p + 1;
        exp_vec = {e_seg, e_dig, fe, !m_pflag};
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        ld_valid   = 1'b0;
        digits_in  = 16'h0000;
        brightness = 3'd7;
        blank_lz   = 1'b0;
        #3;
        total++;
        if (obs !== 13'b0000000_0000_0_1) begin
            bad++;
            $display("[TB] FAIL reset_state: got %b expected %b", obs, 13'b0000000_0000_0_1);
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (obs !== 13'b0000000_0000_0_1) begin
            bad++;
            $display("[TB] FAIL reset_held: got %b expected %b", obs, 13'b0000000_0000_0_1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        applyStimulus(1'b0, 16'h0000);
        total++;
        if ({seg, dig_en} !== {7'b0111111, 4'b0001}) begin
            bad++;
            $display("[TB] FAIL first_output: got %b/%b expected 0111111/0001", seg, dig_en);
        end
    endtask

    task automatic test_scan();
        int ticks;
        ticks = 0;
        for (int i = 0; i < 64; i++) begin
            applyStimulus(1'b0, 16'h0000);
            ticks += int'(frame_tick);
            total++;
            if (obs !== exp_vec) begin
                bad++;
                $display("[TB] FAIL scan cyc %0d: got %b expected %b", i, obs, exp_vec);
            end
        end
        total++;
        if (ticks != 2) begin
            bad++;
            $display("[TB] FAIL scan_ticks: got %0d expected 2", ticks);
        end
    endtask

    task automatic test_load();
        int hits;
        hits = 0;
        repeat (5) applyStimulus(1'b0, 16'h0000);
        for (int i = 0; i < 100; i++) begin
            applyStimulus(i == 0, 16'h1A2F);
            if (dig_en == 4'b0100 && seg == 7'b1110111) hits++;
            total++;
            if (obs !== exp_vec) begin
                bad++;
                $display("[TB] FAIL load cyc %0d: got %b expected %b", i, obs, exp_vec);
            end
        end
        total++;
        if (hits == 0) begin
            bad++;
            $display("[TB] FAIL load_digit2_A: got %0d lit cycles expected nonzero", hits);
        end
    endtask

    task automatic test_back_to_back();
        int ones;
        ones = 0;
        for (int i = 0; i < 160; i++) begin
            applyStimulus(1'b1, (i == 0) ? 16'h1111 : 16'h2222);
            if (dig_en == 4'b0001 && seg == 7'b0000110) ones++;
            total++;
            if (obs !== exp_vec) begin
                bad++;
                $display("[TB] FAIL b2b cyc %0d: got %b expected %b", i, obs, exp_vec);
            end
        end
        repeat (70) applyStimulus(1'b0, 16'h0000);
        total++;
        if (ones != SD) begin
            bad++;
            $display("[TB] FAIL b2b_one_frame: got %0d digit0 '1' cycles expected %0d", ones, SD);
        end
    endtask

    task automatic test_blanking();
        int dark_hits;
        int d1_lit;
        blank_lz = 1'b1;
        for (int v = 0; v < 2; v++) begin
            dark_hits = 0;
            d1_lit    = 0;
            for (int i = 0; i < 100; i++) begin
                applyStimulus(i == 0, (v == 0) ? 16'h0050 : 16'h0000);
                if (i >= 68) begin
                    dark_hits += int'(dig_en[3] | dig_en[2]);
                    d1_lit    += int'(dig_en[1]);
                end
                total++;
                if (obs !== exp_vec) begin
                    bad++;
                    $display("[TB] FAIL blank v%0d cyc %0d: got %b expected %b", v, i, obs, exp_vec);
                end
            end
            total++;
            if (dark_hits != 0 || d1_lit != ((v == 0) ? SD : 0)) begin
                bad++;
                $display("[TB] FAIL blank_lz_%0d: got hi=%0d d1=%0d expected hi=0 d1=%0d",
                         v, dark_hits, d1_lit, (v == 0) ? SD : 0);
            end
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_pwm();
        int lit;
        for (int b = 0; b < 2; b++) begin
            brightness = (b == 0) ? 3'd0 : 3'd3;
            lit = 0;
            for (int i = 0; i < 32; i++) begin
                applyStimulus(1'b0, 16'h0000);
                lit += int'(dig_en != 4'd0);
                total++;
                if (obs !== exp_vec) begin
                    bad++;
                    $display("[TB] FAIL pwm b%0d cyc %0d: got %b expected %b", brightness, i, obs, exp_vec);
                end
            end
            total++;
            if (lit != ((b == 0) ? 4 : 16)) begin
                bad++;
                $display("[TB] FAIL pwm_duty_%0d: got %0d lit expected %0d", brightness, lit, (b == 0) ? 4 : 16);
            end
        end
        brightness = 3'd7;
    endtask

    task automatic test_random();
        logic [15:0] mask;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                brightness = 3'($urandom_range(0, 7));
                blank_lz   = 1'($urandom_range(0, 1));
            end
            case ($urandom_range(0, 4))
                0: mask = 16'hFFFF;
                1: mask = 16'h0FFF;
                2: mask = 16'h00FF;
                3: mask = 16'h000F;
                default: mask = 16'h0000;
            endcase
            applyStimulus($urandom_range(0, 9) == 0, 16'($urandom) & mask);
            total++;
            if (obs !== exp_vec) begin
                bad++;
                $display("[TB] FAIL rand cyc %0d: got %b expected %b", i, obs, exp_vec);
            end
        end
        brightness = 3'd7;
        blank_lz   = 1'b0;
    endtask

    task automatic test_reset_mid();
        int wrong;
        wrong = 0;
        repeat (70) applyStimulus(1'b0, 16'h0000);
        applyStimulus(1'b1, 16'h1234);
        repeat (3) applyStimulus(1'b0, 16'h0000);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (obs !== 13'b0000000_0000_0_1) begin
            bad++;
            $display("[TB] FAIL reset_mid: got %b expected %b", obs, 13'b0000000_0000_0_1);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 80; i++) begin
            applyStimulus(1'b0, 16'h0000);
            if (seg != 7'b0111111) wrong++;
            total++;
            if (obs !== exp_vec) begin
                bad++;
                $display("[TB] FAIL post_reset cyc %0d: got %b expected %b", i, obs, exp_vec);
            end
        end
        total++;
        if (wrong != 0) begin
            bad++;
            $display("[TB] FAIL pending_discarded: got %0d non-zero digit cycles expected 0", wrong);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_scan();
        test_load();
        test_back_to_back();
        test_blanking();
        test_pwm();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Four-digit time-multiplexed seven-segment display driver, downstream of the hex counter/decoder stage. It accepts a 16-bit packed hex value through a valid/ready handshake and decodes each nibble to segments. It scans the four digit enables at a fixed refresh rate with PWM brightness and optional leading-zero blanking. New values are swapped in only at frame boundaries, so the display never shows a torn mix of old and new digits.

## Interface
- SCAN_DIV, 6250: clocks per digit slot (25 MHz → 4 kHz slot, 1 kHz frame); legal range 8..65535
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- digits_in  in  16  packed hex digits; [3:0] = digit 0 (least significant), [15:12] = digit 3
- ld_valid  in  1  digits_in valid
- ld_ready  out  1  driver can accept a value; = !pend_flag
- brightness  in  3  PWM duty code, 0 = dimmest, 7 = full on
- blank_lz  in  1  enable leading-zero blanking
- seg  out  7  segment drive, active-high; bit0 = a … bit6 = g
- dig_en  out  4  digit enables, active-high, at most one bit set
- frame_tick  out  1  one-cycle pulse when a frame completes

## Operation
- Registers:
  - div_cnt [15:0], counts 0..SCAN_DIV-1
  - idx [1:0], current digit
  - disp_reg [15:0], displayed value
  - pend_reg [15:0], pend_flag: one-entry pending buffer
- Load handshake:
  - Accept when ld_valid && ld_ready: pend_reg ← digits_in, pend_flag ← 1.
  - digits_in is sampled only on acceptance.
- Scan:
  - At div_cnt == SCAN_DIV-1: div_cnt ← 0 and idx ← idx+1 mod 4; otherwise div_cnt increments.
  - Order is 0,1,2,3,0…
- Frame end is the cycle with idx==3 && div_cnt==SCAN_DIV-1:
  - If pend_flag: disp_reg ← pend_reg and pend_flag ← 0.
  - frame_tick ← 1 next cycle, whether or not a swap occurs.
- Simultaneous accept and frame end:
  - With pend_flag=0, ld_ready is 1: the value is accepted into pend_reg and is swapped at the next frame end.
  - With pend_flag=1, ld_ready is 0: nothing is accepted, and the swap proceeds.
- Decode of disp_reg nibble[idx]:
  - 0 = 0111111, 1 = 0000110, 2 = 1011011, 3 = 1001111
  - 4 = 1100110, 5 = 1101101, 6 = 1111101, 7 = 0000111
  - 8 = 1111111, 9 = 1101111, A = 1110111, b = 1111100
  - C = 0111001, d = 1011110, E = 1111001, F = 1110001
- Leading-zero blanking (blank_lz=1):
  - Digit k (k=1..3) is blanked when nibbles k..3 are all zero.
  - Digit 0 is never blanked.
  - A blanked digit drives dig_en=0 and seg=0 for its whole slot.
- PWM:
  - on_limit = ((brightness+1) × SCAN_DIV) >> 3, computed in 19 bits.
  - The digit is lit while div_cnt < on_limit.
  - When unlit: dig_en=0 and seg=0.
- dp is not driven; there is no decimal point.

## Timing
- Reset values:
  - seg=0, dig_en=0, frame_tick=0
  - div_cnt=0, idx=0, disp_reg=0, pend_flag=0
  - ld_ready=1 during and after reset
- seg, dig_en and frame_tick are registered: one-cycle latency from (idx, div_cnt).
- First lit output appears the cycle after reset release: digit 0, showing "0".
- Load-to-display latency: from acceptance to the first frame end, at most 4×SCAN_DIV cycles. The new value appears on outputs one cycle after the swap.
- brightness and blank_lz are sampled combinationally every cycle. A change takes effect on the next output register update.
- Reset mid-frame clears all state immediately (asynchronous), including any pending value.
- Consecutive dig_en bits are never both set. Between slots there is no overlap, because outputs switch in the same edge.

## Test plan
- SCAN_DIV=8, brightness=7, blank_lz=0, no load → dig_en cycles 0001,0010,0100,1000 for 8 cycles each, seg=0111111 throughout, frame_tick pulses every 32 cycles.
- Load 16'h1A2F mid-frame → ld_ready drops the cycle after acceptance and stays low until the frame end. Next frame shows digit0=1110001 (F), digit1=1011011 (2), digit2=1110111 (A), digit3=0000110 (1). ld_ready returns to 1 with frame_tick.
- Two back-to-back loads (16'h1111 held with ld_valid, then 16'h2222) → the second is stalled until the swap. The display shows 1111 for exactly one frame, then 2222.
- blank_lz=1, value 16'h0050 → digits 3 and 2 are dark (dig_en bits clear), digit 1 shows 5, digit 0 shows 0. Value 16'h0000 → only digit 0 is lit.
- brightness=0, SCAN_DIV=8 → each digit is lit 1 of 8 cycles. brightness=3 → lit 4 of 8 cycles, at div_cnt 0..3.
- Assert rst_n low mid-slot with a value pending → outputs are 0 immediately and ld_ready=1. After release, the display shows 0000 from digit 0 and the pending value is discarded.
